sd_cmd_seq: RTL and testbench

//  Sequencer for the mode-0 SPI byte port of the memory card. It sends one SD

---
 rtl/sd_pkg.sv | 43 ++++
 rtl/sync2.sv | 24 ++
 rtl/sd_cmd_seq.sv | 182 ++++++++++++++++++
 tb/tb_sd_cmd_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD command sequencer constants, state encoding and frame helper
package sd_pkg;

    // FSM state encoding kept as plain constants so older tools and
    // netlist viewers see a fixed binary code
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR_SET = 3'd1;
    localparam logic [2:0] ST_WR_STB = 3'd2;
    localparam logic [2:0] ST_WR_HLD = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_READ   = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    localparam logic [1:0] SD_START_BITS = 2'b01;
    localparam logic       SD_STOP_BIT   = 1'b1;
    localparam logic [7:0] SD_IDLE_BYTE  = 8'hFF;
    localparam int         R1_BUSY_BIT   = 7;

    // index of the last byte of the 6-byte command frame
    localparam logic [2:0] FRAME_LAST = 3'd5;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        logic [6:0]  crc;
    } sd_cmd_t;

    // Byte idx (0..5) of a command frame, MSB first on the wire
    function automatic logic [7:0] frame_byte(input sd_cmd_t c, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {SD_START_BITS, c.index};
            3'd1:    b = c.arg[31:24];
            3'd2:    b = c.arg[23:16];
            3'd3:    b = c.arg[15:8];
            3'd4:    b = c.arg[7:0];
            3'd5:    b = {c.crc, SD_STOP_BIT};
            default: b = SD_IDLE_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sd_cmd_seq.sv
// rtl/sd_cmd_seq.sv - SD command frame sender and R1 poller over the SPI byte port
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter int POLL_MAX   = 8,
    parameter int RD_CYCLES  = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] arg,
    input  logic [6:0]  crc,
    input  logic        keep_cs,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout,
    output logic        card_n_cs,
    output logic [7:0]  spi_d_out,
    output logic        spi_d_drv,
    input  logic [7:0]  spi_d_in,
    output logic        spi_n_sel,
    output logic        spi_n_we,
    output logic        spi_n_oe,
    input  logic        spi_n_rdy
);

    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);
    localparam logic [7:0] GAP_END   = 8'(GAP_CYCLES);
    localparam logic [7:0] RD_LAST   = 8'(RD_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] byte_idx;
    logic [7:0] polls;
    logic [7:0] cnt;
    logic       is_poll;
    logic       keep_l;
    sd_cmd_t    cmd_l;
    sd_cmd_t    cmd_in;
    logic       rdy_sync;
    logic       rdy_s;

    assign cmd_in = '{index: cmd_index, arg: arg, crc: crc};

    // n_rdy is driven by the port's own shifter clock domain
    sync2 #(.RESET_VAL(1'b0)) u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (spi_n_rdy),
        .q   (rdy_sync)
    );

    // rdy_s high means the port has finished shifting the last byte
    assign rdy_s = ~rdy_sync;

    // Sequencer: every port strobe is a registered output updated on the
    // transition into the state that owns it, so strobes never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_idx  <= 3'd0;
            polls     <= 8'd0;
            cnt       <= 8'd0;
            is_poll   <= 1'b0;
            keep_l    <= 1'b0;
            cmd_l     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            r1        <= SD_IDLE_BYTE;
            timeout   <= 1'b0;
            card_n_cs <= 1'b1;
            spi_d_out <= 8'h00;
            spi_d_drv <= 1'b0;
            spi_n_sel <= 1'b1;
            spi_n_we  <= 1'b1;
            spi_n_oe  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // command fields are latched so the CPU may change them mid-frame
                        cmd_l     <= cmd_in;
                        keep_l    <= keep_cs;
                        card_n_cs <= 1'b0;
                        busy      <= 1'b1;
                        byte_idx  <= 3'd0;
                        polls     <= 8'd0;
                        timeout   <= 1'b0;
                        is_poll   <= 1'b0;
                        spi_d_out <= frame_byte(cmd_in, 3'd0);
                        spi_d_drv <= 1'b1;
                        spi_n_sel <= 1'b0;
                        state     <= ST_WR_SET;
                    end
                end

                ST_WR_SET: begin
                    // data has been stable on the bus for one clock before the strobe
                    spi_n_we <= 1'b0;
                    state    <= ST_WR_STB;
                end

                ST_WR_STB: begin
                    // port latches on this rising edge; bus stays driven one more clock
                    spi_n_we <= 1'b1;
                    state    <= ST_WR_HLD;
                end

                ST_WR_HLD: begin
                    spi_d_drv <= 1'b0;
                    cnt       <= 8'd0;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    // the gap covers the port's latency in raising n_rdy after the strobe
                    if (cnt != GAP_END) begin
                        cnt <= cnt + 8'd1;
                    end else if (rdy_s) begin
                        if (!is_poll && byte_idx != FRAME_LAST) begin
                            byte_idx  <= byte_idx + 3'd1;
                            spi_d_out <= frame_byte(cmd_l, byte_idx + 3'd1);
                            spi_d_drv <= 1'b1;
                            state     <= ST_WR_SET;
                        end else begin
                            spi_n_oe <= 1'b0;
                            cnt      <= 8'd0;
                            state    <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    if (cnt != RD_LAST) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        spi_n_oe <= 1'b1;
                        if (!is_poll) begin
                            // byte clocked in during the CRC byte is never an R1
                            is_poll   <= 1'b1;
                            spi_d_out <= SD_IDLE_BYTE;
                            spi_d_drv <= 1'b1;
                            state     <= ST_WR_SET;
                        end else if (!spi_d_in[R1_BUSY_BIT]) begin
                            r1        <= spi_d_in;
                            spi_n_sel <= 1'b1;
                            card_n_cs <= ~keep_l;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_FIN;
                        end else if (polls == POLL_LAST) begin
                            r1        <= SD_IDLE_BYTE;
                            timeout   <= 1'b1;
                            spi_n_sel <= 1'b1;
                            card_n_cs <= ~keep_l;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_FIN;
                        end else begin
                            polls     <= polls + 8'd1;
                            spi_d_out <= SD_IDLE_BYTE;
                            spi_d_drv <= 1'b1;
                            state     <= ST_WR_SET;
                        end
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb/tb_sd_cmd_seq.sv - scoreboard bench for sd_cmd_seq with a behavioural SPI port
module tb_sd_cmd_seq;

    localparam int POLL_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] arg = '0;
    logic [6:0]  crc = '0;
    logic        keep_cs = 1'b0;
    logic        busy, done, timeout, card_n_cs;
    logic [7:0]  r1, spi_d_out, spi_d_in;
    logic        spi_d_drv, spi_n_sel, spi_n_we, spi_n_oe, spi_n_rdy;

    typedef struct {
        logic [7:0] r1;
        logic       to;
        logic       cs;
        int         writes;
    } res_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_bytes[$];
    res_t       exp_res[$];
    logic [7:0] reply_q[$];

    int         busy_clocks = 3;
    int         busy_left = 0;
    logic       port_rdy = 1'b0;
    logic [7:0] rx = 8'h00;
    logic [7:0] frame_rx = 8'h00;
    int         wcount = 0;
    logic       prev_we = 1'b1;
    logic       spacing_chk = 1'b0;
    logic       have_fall = 1'b0;
    int         last_fall = 0;
    int         cyc = 0;
    int         done_count = 0;
    logic       prev_done = 1'b0;

    assign spi_n_rdy = port_rdy;
    assign spi_d_in  = spi_n_oe ? 8'h00 : rx;

    always #5 clk = ~clk;

    sd_cmd_seq #(.POLL_MAX(POLL_MAX), .RD_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index), .arg(arg),
        .crc(crc), .keep_cs(keep_cs), .busy(busy), .done(done), .r1(r1),
        .timeout(timeout), .card_n_cs(card_n_cs), .spi_d_out(spi_d_out),
        .spi_d_drv(spi_d_drv), .spi_d_in(spi_d_in), .spi_n_sel(spi_n_sel),
        .spi_n_we(spi_n_we), .spi_n_oe(spi_n_oe), .spi_n_rdy(spi_n_rdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural SPI port, bus checker and scoreboard monitor, all on the falling edge
    always @(negedge clk) begin
        cyc++;
        chk("bus_drv_and_oe", {31'd0, spi_d_drv & ~spi_n_oe}, 0);
        chk("we_and_oe_low", {31'd0, ~spi_n_we & ~spi_n_oe}, 0);
        if (rst) begin
            busy_left = 0;
            port_rdy  = 1'b0;
            prev_we   = 1'b1;
        end else begin
            if (!spi_n_we) chk("we_while_port_busy", {31'd0, port_rdy}, 0);
            if (prev_we && !spi_n_we) begin
                if (spacing_chk && have_fall) chk("strobe_spacing_ge_43", {31'd0, (cyc - last_fall) >= 43}, 1);
                last_fall = cyc;
                have_fall = 1'b1;
            end
            if (!prev_we && spi_n_we) begin
                if (exp_bytes.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%0h expected=none", spi_d_out);
                end else begin
                    chk("mosi_byte", {24'd0, spi_d_out}, {24'd0, exp_bytes.pop_front()});
                end
                chk("drv_held_after_strobe", {31'd0, spi_d_drv}, 1);
                chk("n_sel_during_write", {31'd0, spi_n_sel}, 0);
                if (wcount < 6) rx = frame_rx;
                else if (wcount - 6 < reply_q.size()) rx = reply_q[wcount-6];
                else rx = 8'hFF;
                wcount++;
                busy_left = busy_clocks;
                port_rdy  = 1'b1;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) port_rdy = 1'b0;
            end
            prev_we = spi_n_we;
        end
        if (prev_done) chk("done_one_clk", {31'd0, done}, 0);
        if (done === 1'b1) begin
            res_t r;
            done_count++;
            if (exp_res.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                r = exp_res.pop_front();
                chk("r1", {24'd0, r1}, {24'd0, r.r1});
                chk("timeout", {31'd0, timeout}, {31'd0, r.to});
                chk("card_n_cs_at_done", {31'd0, card_n_cs}, {31'd0, r.cs});
                chk("write_count", wcount, r.writes);
                chk("busy_at_done", {31'd0, busy}, 0);
                chk("n_sel_at_done", {31'd0, spi_n_sel}, 0 + 1);
            end
        end
        prev_done = done;
    end

    // Reference model: frame bytes, then 0xFF polls until a byte with bit 7 clear
    task automatic push_model(input logic [5:0] ci, input logic [31:0] a, input logic [6:0] c, input logic k);
        res_t r;
        logic [7:0] b;
        logic found;
        exp_bytes.push_back({2'b01, ci});
        for (int s = 3; s >= 0; s--) exp_bytes.push_back(8'((a >> (8 * s)) & 32'hFF));
        exp_bytes.push_back({c, 1'b1});
        found    = 1'b0;
        r.r1     = 8'hFF;
        r.to     = 1'b1;
        r.writes = 6 + POLL_MAX;
        for (int p = 0; p < POLL_MAX && !found; p++) begin
            exp_bytes.push_back(8'hFF);
            b = (p < reply_q.size()) ? reply_q[p] : 8'hFF;
            if (b < 8'h80) begin
                found    = 1'b1;
                r.r1     = b;
                r.to     = 1'b0;
                r.writes = 7 + p;
            end
        end
        r.cs = ~k;
        exp_res.push_back(r);
    endtask

    task automatic pulse_start(input logic [5:0] ci, input logic [31:0] a, input logic [6:0] c, input logic k);
        @(posedge clk); #1;
        cmd_index = ci; arg = a; crc = c; keep_cs = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cmd_index = 6'($urandom); arg = $urandom; crc = 7'($urandom);
    endtask

    task automatic run_cmd(input logic [5:0] ci, input logic [31:0] a, input logic [6:0] c,
                           input logic k, input int bc, input logic spc);
        int dc0;
        busy_clocks = bc;
        spacing_chk = spc;
        have_fall   = 1'b0;
        wcount      = 0;
        frame_rx    = 8'($urandom_range(0, 255));
        push_model(ci, a, c, k);
        dc0 = done_count;
        pulse_start(ci, a, c, k);
        chk("busy_after_start", {31'd0, busy}, 1);
        for (int i = 0; i < 20000 && done_count == dc0; i++) @(negedge clk);
        if (done_count == dc0) begin
            total++;
            bad++;
            $display("FAIL done_wait_expired actual=none expected=done");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 0);
        chk({tag, "_r1"}, {24'd0, r1}, 32'hFF);
        chk({tag, "_card_n_cs"}, {31'd0, card_n_cs}, 1);
        chk({tag, "_n_sel"}, {31'd0, spi_n_sel}, 1);
        chk({tag, "_n_we"}, {31'd0, spi_n_we}, 1);
        chk({tag, "_n_oe"}, {31'd0, spi_n_oe}, 1);
        chk({tag, "_drv"}, {31'd0, spi_d_drv}, 0);
        chk({tag, "_d_out"}, {24'd0, spi_d_out}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        int nff;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // CMD0: card answers FF then 01
        reply_q = '{8'hFF, 8'h01};
        run_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 3, 1'b0);
        repeat (4) @(negedge clk);
        chk("cs_idle_after_cmd0", {31'd0, card_n_cs}, 1);

        // card never answers: full poll budget then timeout
        reply_q.delete();
        run_cmd(6'd8, 32'h000001AA, 7'h43, 1'b0, 2, 1'b0);

        // slow port: 40 clocks busy per byte
        reply_q = '{8'hFF, 8'hC1, 8'h05};
        run_cmd(6'd55, 32'h0, 7'h32, 1'b0, 40, 1'b1);

        // keep_cs: chip select stays asserted after done
        reply_q = '{8'h00};
        run_cmd(6'd17, 32'h00000200, 7'h2A, 1'b1, 3, 1'b0);
        repeat (6) @(negedge clk);
        chk("cs_kept_low_idle", {31'd0, card_n_cs}, 0);

        // start while busy is ignored, then reset mid-frame
        reply_q = '{8'hFF, 8'h01};
        busy_clocks = 4; spacing_chk = 1'b0; have_fall = 1'b0; wcount = 0;
        frame_rx = 8'h00;
        push_model(6'd9, 32'hDEADBEEF, 7'h11, 1'b0);
        dc0 = done_count;
        pulse_start(6'd9, 32'hDEADBEEF, 7'h11, 1'b0);
        for (int i = 0; i < 2000 && wcount < 1; i++) @(negedge clk);
        chk("reached_first_write", {31'd0, wcount >= 1}, 1);
        pulse_start(6'd12, 32'h12345678, 7'h7F, 1'b1);
        for (int i = 0; i < 2000 && wcount < 3; i++) @(negedge clk);
        chk("reached_third_write", {31'd0, wcount >= 3}, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_bytes.delete();
        exp_res.delete();
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        chk("no_done_before_rst", done_count, dc0);
        rst = 1'b0;
        reply_q = '{8'h01};
        run_cmd(6'd1, 32'h40000000, 7'h7C, 1'b0, 3, 1'b0);

        // randomized commands
        for (int n = 0; n < 8; n++) begin
            reply_q.delete();
            nff = $urandom_range(0, 9);
            for (int j = 0; j < nff; j++)
                reply_q.push_back(($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(128, 255)));
            reply_q.push_back(8'($urandom_range(0, 127)));
            run_cmd(6'($urandom), $urandom, 7'($urandom), 1'($urandom), $urandom_range(1, 8), 1'b0);
        end

        chk("scoreboard_drained", exp_bytes.size() + exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
